// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_AW = 32;
  localparam int unsigned MEM_DW = 32;

  // Owner codes as seen on the owner output.
  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_IF   = 2'd1;
  localparam logic [1:0] OWNER_DM   = 2'd2;

  // State values equal the owner codes, so owner is simply a copy of the state.
  typedef enum logic [1:0] {
    IDLE    = OWNER_NONE,
    IF_XFER = OWNER_IF,
    DM_XFER = OWNER_DM
  } state_e;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the fetch port, the data port and the shared-memory port.
interface mem_arb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic [1:0]    owner;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata, owner
  );

  // Requesters plus memory view.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata, owner
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Priority select (data over fetch) with a fetch starvation counter.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arb_en,
  input  logic i_if_req,
  input  logic i_if_mask,
  input  logic i_dm_req,
  input  logic i_dm_mask,
  output logic o_grant_if,
  output logic o_grant_dm
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;
  logic       w_if_pend;
  logic       w_dm_pend;
  logic       w_starved;

  // Data wins unless fetch has waited through LIMIT data grants.
  always_comb begin
    w_if_pend  = i_if_req && !i_if_mask;
    w_dm_pend  = i_dm_req && !i_dm_mask;
    w_starved  = (r_starve_cnt == LIMIT);
    o_grant_dm = i_arb_en && w_dm_pend && !(w_if_pend && w_starved);
    o_grant_if = i_arb_en && w_if_pend && !o_grant_dm;
  end

  // Count data grants taken while fetch waits; clear on any fetch grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (o_grant_if) begin
      r_starve_cnt <= '0;
    end else if (o_grant_dm && w_if_pend && (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one variable-latency memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = MEM_AW,
  parameter int unsigned DW           = MEM_DW,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);
  state_e        r_state;
  state_e        w_next;
  logic          w_arb_en;
  logic          w_grant_if;
  logic          w_grant_dm;
  logic          w_done_if;
  logic          w_done_dm;

  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_if_ack;
  logic          r_dm_ack;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;
  logic [1:0]    r_owner;

  // The ack register doubles as the mask: a requester is ignored in its ack cycle.
  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk        (clk),
    .rst        (rst),
    .i_arb_en   (w_arb_en),
    .i_if_req   (bus.if_req),
    .i_if_mask  (r_if_ack),
    .i_dm_req   (bus.dm_req),
    .i_dm_mask  (r_dm_ack),
    .o_grant_if (w_grant_if),
    .o_grant_dm (w_grant_dm)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state: grant from IDLE, return to IDLE on mem_ready.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_dm)      w_next = DM_XFER;
        else if (w_grant_if) w_next = IF_XFER;
      end
      IF_XFER, DM_XFER: begin
        if (bus.mem_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Output decode: arbitration enable and per-owner completion strobes.
  always_comb begin
    w_arb_en  = (r_state == IDLE);
    w_done_if = (r_state == IF_XFER) && bus.mem_ready;
    w_done_dm = (r_state == DM_XFER) && bus.mem_ready;
  end

  // Registered memory command, acks, read data and owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_owner     <= OWNER_NONE;
    end else begin
      r_if_ack <= w_done_if;
      r_dm_ack <= w_done_dm;
      r_owner  <= w_next;
      if (w_grant_dm) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.dm_we;
        r_mem_addr  <= bus.dm_addr;
        r_mem_wdata <= bus.dm_wdata;
      end else if (w_grant_if) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= bus.if_addr;
      end else if (w_done_if || w_done_dm) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
      if (w_done_if)              r_if_rdata <= bus.mem_rdata;
      if (w_done_dm && !r_mem_we) r_dm_rdata <= bus.mem_rdata;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.owner     = r_owner;

endmodule
